vga_pxl_unpack_fifo: RTL and testbench
======================================

// Module: vga_pxl_unpack_fifo
// PURPOSE
//  Downstream of vga_axi_mem_ctrl: buffers the 64-bit AXI read-data words it
//  receives and unpacks each word into 16-bit pixels. Pixels go to the VGA
//  colour outputs on demand from the timing generator (pxl_req_i).
//  Decouples AXI read latency from the fixed pixel rate; reports underflow.
// PARAMETERS
//  DATA_WIDTH   64  width of the incoming word (equals AXI_DATA_WIDTH)
//  PXL_WIDTH    16  bits per pixel in memory; DATA_WIDTH % PXL_WIDTH == 0
//  COLOUR_DEPTH 4   bits per R/G/B channel; 3*COLOUR_DEPTH <= PXL_WIDTH
//  FIFO_DEPTH   8   word FIFO entries; power of 2, >= 2
// PORTS
//  clk           in   1                  system clock
//  rst_n         in   1                  synchronous active-low reset
//  flush_i       in   1                  frame-start flush (pulse at vsync)
//  data_i        in   DATA_WIDTH         word from vga_axi_mem_ctrl
//  data_valid_i  in   1                  data_i valid
//  data_rdy_o    out  1                  FIFO can accept a word
//  pxl_req_i     in   1                  timing gen needs one pixel this cycle
//  pxl_r_o       out  COLOUR_DEPTH       red
//  pxl_g_o       out  COLOUR_DEPTH       green
//  pxl_b_o       out  COLOUR_DEPTH       blue
//  pxl_valid_o   out  1                  colour outputs hold a real pixel
//  underflow_o   out  1                  sticky: request served with no data
//  fill_lvl_o    out  $clog2(FIFO_DEPTH+1) words held in FIFO
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): FIFO empty, pointers 0, unpacker EMPTY,
//    idx 0, all outputs 0 (data_rdy_o=0 during reset, 1 the cycle after).
//  - data_rdy_o = ~flush_i & (fill_lvl_o < FIFO_DEPTH), from registered count.
//    Push on data_valid_i & data_rdy_o; visible in fill_lvl_o next cycle.
//    Full + simultaneous pop: no push that cycle (no combinational path).
//  - Pixel k of a word = data_i[k*PXL_WIDTH +: PXL_WIDTH], k=0 first.
//    Within a pixel: R=[3C-1:2C], G=[2C-1:C], B=[C-1:0], C=COLOUR_DEPTH.
//  - Unpacker FSM, PPW = DATA_WIDTH/PXL_WIDTH, idx width $clog2(PPW):
//    EMPTY : FIFO non-empty -> pop into shift word, idx=0, go LOADED.
//    LOADED: on pxl_req_i emit pixel idx; idx==PPW-1 -> pop+reload (idx=0,
//            stay LOADED) if FIFO non-empty, else EMPTY; otherwise idx++.
//  - No bypass: word pushed at cycle n is poppable at n+1, loaded at n+2,
//    first request served at n+2 with pixel on outputs at n+3.
//  - Output latency 1: request at cycle t -> colour/pxl_valid_o at t+1.
//    No request at t -> pxl_valid_o=0 and colour=0 at t+1.
//  - Request in EMPTY: colour=0, pxl_valid_o=0 next cycle, underflow_o=1
//    next cycle; stays 1 until flush_i or reset. FSM state unchanged.
//  - flush_i (priority over push, pop, request): next cycle FIFO empty,
//    fill_lvl_o=0, EMPTY, idx=0, underflow_o=0, pxl_valid_o=0.
//  - fill_lvl_o counts FIFO only (not the word held in the unpacker).
//    Simultaneous push+pop leaves it unchanged; pointers wrap mod FIFO_DEPTH.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with valid data -> all outputs 0, no push;
//    cycle after release data_rdy_o=1, fill_lvl_o=0.
//  2 Unpack: push 64'h0FFF_0ABC_0123_0F00, request 4 consecutive cycles from
//    n+2 -> RGB F/0/0, 1/2/3, A/B/C, F/F/F with pxl_valid_o=1, no underflow.
//  3 Full: push 9 words with pxl_req_i=0 -> 8 FIFO + 1 unpacker accepted,
//    10th held off (data_rdy_o=0, fill_lvl_o=8); 4 requests free one slot.
//  4 Underflow: request with FIFO empty -> pxl_valid_o=0, colour 0,
//    underflow_o=1 stays high across later valid pixels until flush_i.
//  5 Flush mid-word: flush_i after 2 of 4 pixels with 3 words queued ->
//    fill_lvl_o=0, next request underflows; new word restarts at pixel 0.
//  6 Streaming: push 1 word/4 cycles, request every cycle for 64 pixels ->
//    incrementing pattern intact across pointer wrap, underflow_o=0.

Source files
------------

// File: rtl/vga_pxl_unpack_fifo.sv
// Word FIFO between the AXI read path and the VGA pixel pipe: buffers 64-bit words and
// unpacks each one into 16-bit pixels, emitting R/G/B one cycle after each pixel request.
module vga_pxl_unpack_fifo #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned PXL_WIDTH    = 16,
  parameter int unsigned COLOUR_DEPTH = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               data_valid_i,
  output logic                               data_rdy_o,
  input  logic                               pxl_req_i,
  output logic [COLOUR_DEPTH-1:0]            pxl_r_o,
  output logic [COLOUR_DEPTH-1:0]            pxl_g_o,
  output logic [COLOUR_DEPTH-1:0]            pxl_b_o,
  output logic                               pxl_valid_o,
  output logic                               underflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_lvl_o
);

  localparam int unsigned PPW  = DATA_WIDTH / PXL_WIDTH;
  localparam int unsigned IdxW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned C    = COLOUR_DEPTH;

  typedef enum logic {StEmpty, StLoaded} state_e;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [C-1:0]            r_q, g_q, b_q;
  logic                    valid_q, underflow_q;

  logic                    push, pop, fifo_empty, last_pxl;
  logic [PXL_WIDTH-1:0]    pxl_arr [PPW];
  logic [PXL_WIDTH-1:0]    cur_pxl;

  // Ready comes from the registered count only, so a pop never frees a slot the same cycle.
  assign data_rdy_o = rst_n & ~flush_i & (count_q < CntW'(FIFO_DEPTH));

  always_comb begin
    fifo_empty = (count_q == '0);
    push       = data_valid_i & data_rdy_o;
    last_pxl   = (idx_q == IdxW'(PPW - 1));
    pop        = ~flush_i & ~fifo_empty &
                 ((state_q == StEmpty) | ((state_q == StLoaded) & pxl_req_i & last_pxl));
    for (int k = 0; k < PPW; k++) begin
      pxl_arr[k] = word_q[k*PXL_WIDTH +: PXL_WIDTH];
    end
    cur_pxl = pxl_arr[idx_q];
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      idx_q       <= '0;
      word_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= StEmpty;
      idx_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      unique case (state_q)
        StEmpty: begin
          if (pxl_req_i) underflow_q <= 1'b1;
          if (!fifo_empty) begin
            word_q  <= mem_q[rd_ptr_q];
            idx_q   <= '0;
            state_q <= StLoaded;
          end
        end
        StLoaded: begin
          if (pxl_req_i) begin
            r_q     <= cur_pxl[3*C-1:2*C];
            g_q     <= cur_pxl[2*C-1:C];
            b_q     <= cur_pxl[C-1:0];
            valid_q <= 1'b1;
            if (last_pxl) begin
              idx_q <= '0;
              if (!fifo_empty) word_q  <= mem_q[rd_ptr_q];
              else             state_q <= StEmpty;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign pxl_r_o     = r_q;
  assign pxl_g_o     = g_q;
  assign pxl_b_o     = b_q;
  assign pxl_valid_o = valid_q;
  assign underflow_o = underflow_q;
  assign fill_lvl_o  = count_q;

endmodule

// File: tb/tb_vga_pxl_unpack_fifo.sv
// Directed bench for vga_pxl_unpack_fifo: reset, unpack order, full, underflow, flush, streaming.
module tb_vga_pxl_unpack_fifo;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, data_valid_i, data_rdy_o, pxl_req_i;
  logic [63:0] data_i;
  logic [3:0]  pxl_r_o, pxl_g_o, pxl_b_o;
  logic        pxl_valid_o, underflow_o;
  logic [3:0]  fill_lvl_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_pxl_unpack_fifo #(
    .DATA_WIDTH  (64),
    .PXL_WIDTH   (16),
    .COLOUR_DEPTH(4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .data_rdy_o  (data_rdy_o),
    .pxl_req_i   (pxl_req_i),
    .pxl_r_o     (pxl_r_o),
    .pxl_g_o     (pxl_g_o),
    .pxl_b_o     (pxl_b_o),
    .pxl_valid_o (pxl_valid_o),
    .underflow_o (underflow_o),
    .fill_lvl_o  (fill_lvl_o)
  );

  // Four pixels base..base+3, each a 12-bit RGB value in the low bits of its 16-bit slot.
  function automatic logic [63:0] make_word(input logic [11:0] base);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = {4'h0, base + 12'(k)};
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; data_valid_i = 1'b1; pxl_req_i = 1'b1;
    data_i = make_word(12'h123);
    repeat (3) step();
    total++;
    if ({pxl_r_o, pxl_g_o, pxl_b_o} !== 12'h000) begin
      bad++; $display("FAIL reset_colour got=%h exp=000", {pxl_r_o, pxl_g_o, pxl_b_o});
    end
    total++;
    if ({data_rdy_o, pxl_valid_o, underflow_o, fill_lvl_o} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000",
                      {data_rdy_o, pxl_valid_o, underflow_o, fill_lvl_o});
    end
    rst_n = 1'b1; data_valid_i = 1'b0; pxl_req_i = 1'b0;
    #1;
    total++;
    if (data_rdy_o !== 1'b1) begin
      bad++; $display("FAIL reset_rdy_after got=%b exp=1", data_rdy_o);
    end
    step();
    total++;
    if (fill_lvl_o !== 4'd0) begin
      bad++; $display("FAIL reset_fill got=%0d exp=0", fill_lvl_o);
    end
  endtask

  task automatic test_unpack();
    logic [11:0] exp_rgb [4];
    exp_rgb[0] = 12'hF00; exp_rgb[1] = 12'h123; exp_rgb[2] = 12'hABC; exp_rgb[3] = 12'hFFF;
    data_i = 64'h0FFF_0ABC_0123_0F00; data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    total++;
    if (fill_lvl_o !== 4'd1) begin
      bad++; $display("FAIL unpack_fill_push got=%0d exp=1", fill_lvl_o);
    end
    step();
    total++;
    if (fill_lvl_o !== 4'd0) begin
      bad++; $display("FAIL unpack_fill_load got=%0d exp=0", fill_lvl_o);
    end
    pxl_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({pxl_valid_o, underflow_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {2'b10, exp_rgb[k]}) begin
        bad++; $display("FAIL unpack_pxl%0d got=%b_%b_%h exp=1_0_%h", k, pxl_valid_o,
                        underflow_o, {pxl_r_o, pxl_g_o, pxl_b_o}, exp_rgb[k]);
      end
    end
    pxl_req_i = 1'b0;
    step();
    total++;
    if ({pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== 13'h0) begin
      bad++; $display("FAIL unpack_idle got=%h exp=0", {pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o});
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) begin
      data_i = make_word(12'h800 + 12'(i * 16)); data_valid_i = 1'b1;
      #1;
      total++;
      if (data_rdy_o !== 1'b1) begin
        bad++; $display("FAIL full_rdy_push%0d got=%b exp=1", i, data_rdy_o);
      end
      step();
    end
    data_i = make_word(12'h890);
    #1;
    total++;
    if ({data_rdy_o, fill_lvl_o} !== {1'b0, 4'd8}) begin
      bad++; $display("FAIL full_held got=rdy%b/fill%0d exp=rdy0/fill8", data_rdy_o, fill_lvl_o);
    end
    step();
    total++;
    if (fill_lvl_o !== 4'd8) begin
      bad++; $display("FAIL full_no_push got=%0d exp=8", fill_lvl_o);
    end
    data_valid_i = 1'b0; pxl_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {1'b1, 12'h800 + 12'(k)}) begin
        bad++; $display("FAIL full_pxl%0d got=%h exp=%h", k,
                        {pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o}, {1'b1, 12'h800 + 12'(k)});
      end
    end
    pxl_req_i = 1'b0;
    #1;
    total++;
    if ({data_rdy_o, fill_lvl_o} !== {1'b1, 4'd7}) begin
      bad++; $display("FAIL full_freed got=rdy%b/fill%0d exp=rdy1/fill7", data_rdy_o, fill_lvl_o);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++;
    if (fill_lvl_o !== 4'd0) begin
      bad++; $display("FAIL full_flush_fill got=%0d exp=0", fill_lvl_o);
    end
  endtask

  task automatic test_underflow();
    pxl_req_i = 1'b1;
    step();
    pxl_req_i = 1'b0;
    total++;
    if ({underflow_o, pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {2'b10, 12'h000}) begin
      bad++; $display("FAIL uf_first got=%b_%b_%h exp=1_0_000", underflow_o, pxl_valid_o,
                      {pxl_r_o, pxl_g_o, pxl_b_o});
    end
    step();
    total++;
    if (underflow_o !== 1'b1) begin
      bad++; $display("FAIL uf_sticky got=%b exp=1", underflow_o);
    end
    data_i = make_word(12'hA50); data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    step();
    pxl_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({underflow_o, pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !==
          {2'b11, 12'hA50 + 12'(k)}) begin
        bad++; $display("FAIL uf_pxl%0d got=%b_%b_%h exp=1_1_%h", k, underflow_o, pxl_valid_o,
                        {pxl_r_o, pxl_g_o, pxl_b_o}, 12'hA50 + 12'(k));
      end
    end
    pxl_req_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++;
    if ({underflow_o, pxl_valid_o, fill_lvl_o} !== 6'b0) begin
      bad++; $display("FAIL uf_flush got=%b exp=000000", {underflow_o, pxl_valid_o, fill_lvl_o});
    end
  endtask

  task automatic test_flush_mid_word();
    for (int i = 0; i < 4; i++) begin
      data_i = make_word(12'h900 + 12'(i * 16)); data_valid_i = 1'b1;
      step();
    end
    data_valid_i = 1'b0;
    total++;
    if (fill_lvl_o !== 4'd3) begin
      bad++; $display("FAIL flush_queued got=%0d exp=3", fill_lvl_o);
    end
    pxl_req_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if ({pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {1'b1, 12'h900 + 12'(k)}) begin
        bad++; $display("FAIL flush_pre_pxl%0d got=%h exp=%h", k,
                        {pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o}, {1'b1, 12'h900 + 12'(k)});
      end
    end
    // Flush wins over a simultaneous push and request.
    flush_i = 1'b1; data_valid_i = 1'b1; data_i = make_word(12'hEEE);
    #1;
    total++;
    if (data_rdy_o !== 1'b0) begin
      bad++; $display("FAIL flush_rdy got=%b exp=0", data_rdy_o);
    end
    step();
    flush_i = 1'b0; data_valid_i = 1'b0;
    total++;
    if ({fill_lvl_o, pxl_valid_o, underflow_o} !== 6'b0) begin
      bad++; $display("FAIL flush_state got=%b exp=000000", {fill_lvl_o, pxl_valid_o, underflow_o});
    end
    step();
    pxl_req_i = 1'b0;
    total++;
    if ({underflow_o, pxl_valid_o} !== 2'b10) begin
      bad++; $display("FAIL flush_uf got=%b exp=10", {underflow_o, pxl_valid_o});
    end
    data_i = make_word(12'hB70); data_valid_i = 1'b1;
    step();
    data_valid_i = 1'b0;
    step();
    pxl_req_i = 1'b1;
    step();
    pxl_req_i = 1'b0;
    total++;
    if ({pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {1'b1, 12'hB70}) begin
      bad++; $display("FAIL flush_restart got=%h exp=%h",
                      {pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o}, {1'b1, 12'hB70});
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic test_streaming();
    logic        req_prev;
    logic [11:0] exp_pv;
    for (int c = 0; c < 66; c++) begin
      data_valid_i = ((c % 4) == 0) && (c < 64);
      data_i       = make_word(12'h400 + 12'((c / 4) * 4));
      pxl_req_i    = (c >= 2);
      req_prev     = pxl_req_i;
      exp_pv       = 12'h400 + 12'(c - 2);
      step();
      if (req_prev) begin
        total++;
        if ({underflow_o, pxl_valid_o, pxl_r_o, pxl_g_o, pxl_b_o} !== {2'b01, exp_pv}) begin
          bad++; $display("FAIL stream_pxl%0d got=%b_%b_%h exp=0_1_%h", c - 2, underflow_o,
                          pxl_valid_o, {pxl_r_o, pxl_g_o, pxl_b_o}, exp_pv);
        end
      end
    end
    data_valid_i = 1'b0; pxl_req_i = 1'b0;
    step();
    total++;
    if ({underflow_o, pxl_valid_o, fill_lvl_o} !== 6'b0) begin
      bad++; $display("FAIL stream_end got=%b exp=000000", {underflow_o, pxl_valid_o, fill_lvl_o});
    end
  endtask

  initial begin
    test_reset();
    test_unpack();
    test_full();
    test_underflow();
    test_flush_mid_word();
    test_streaming();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
